bht_ctrl: RTL and testbench
===========================

# bht_ctrl

Controller for a single-port 2-bit branch history table (1024 × 2 by default). It shares the table's one port between fetch-stage prediction lookups and execute-stage resolution updates, and queues the updates. On every reset it sequences a clear sweep of the whole table. Each counter update is a read-modify-write that follows the team's 2-bit predictor state scheme.

## Interface
Parameters:
- ADDR_W, default 10: table index width; table depth is 2^ADDR_W.
- QDEPTH, default 4: update queue depth (power of two, ≥2).

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- lk_valid  in  1  lookup request.
- lk_addr  in  ADDR_W  lookup index.
- lk_ready  out  1  lookup accepted this cycle when high together with lk_valid.
- lk_pred_valid  out  1  registered lookup response strobe.
- lk_pred  out  1  predicted taken (lk_state[1]).
- lk_state  out  2  counter value read.
- up_valid  in  1  resolved-branch update request.
- up_addr  in  ADDR_W  update index.
- up_taken  in  1  actual outcome.
- up_ready  out  1  update accepted into queue when high with up_valid.
- tbl_addr  out  ADDR_W  table address.
- tbl_we  out  1  table write enable.
- tbl_wdata  out  2  table write data.
- tbl_rdata  in  2  table read data; combinational from tbl_addr.
- init_busy  out  1  clear sweep in progress.

## Operation
States: INIT, RUN.

INIT
- sweep_ctr starts at 0.
- Each cycle: tbl_addr=sweep_ctr, tbl_we=1, tbl_wdata=00, then sweep_ctr increments.
- After writing address 2^ADDR_W−1, the FSM moves to RUN.
- lk_ready=0, up_ready=0, init_busy=1.

RUN: one table operation per cycle, chosen by priority:
1. Queue full (count==QDEPTH): drain the queue head; lk_ready=0.
2. Otherwise, lk_valid=1: lookup granted (lk_ready=1), with tbl_addr=lk_addr and tbl_we=0.
3. Otherwise, queue non-empty: drain the queue head.
4. Otherwise: idle, with tbl_we=0 and tbl_addr=0.

lk_ready is combinational: RUN && count<QDEPTH. It does not depend on lk_valid.

Drain (read-modify-write in one cycle):
- tbl_addr=head.addr, tbl_we=1, tbl_wdata=next(tbl_rdata, head.taken), then pop the head.

Counter next-state (taken / not taken):
- 00 → 01 / 00
- 01 → 11 / 00
- 10 → 11 / 00
- 11 → 11 / 10

Update queue:
- FIFO of {addr, taken}.
- up_ready = RUN && count<QDEPTH.
- An enqueue and a dequeue in the same cycle are legal when not full; count is unchanged.
- At full, no enqueue is allowed even though a drain happens that cycle.

Hazards:
- Lookups are not forwarded from queued updates. A lookup returns the table contents as they are, which may be stale.
- Updates to the same address drain strictly in order.

Lookup response:
- On handshake, lk_state and lk_pred are registered from tbl_rdata.
- lk_pred_valid=1 for exactly the next cycle.

## Timing
Reset (rst_n=0 at an edge):
- FSM=INIT, sweep_ctr=0, queue emptied, lk_pred_valid=0, lk_pred=0, lk_state=00.
- While rst_n=0: tbl_we=0, init_busy=1, lk_ready=0, up_ready=0.
- A reset mid-sweep or mid-drain discards all pending updates and restarts the sweep at address 0. A lookup response due in that cycle is suppressed.

Sweep timing:
- The first cycle with rst_n=1 writes address 0.
- Address 2^ADDR_W−1 is written in cycle 2^ADDR_W.
- init_busy=0 and readies become valid in the following cycle.

Latencies:
- Lookup: response one cycle after the handshake.
- Update: enqueue to table write is at least 1 cycle. It is unbounded under lookup pressure until the queue fills, after which the drain is immediate.
- Sustained throughput: one operation per cycle.

## Test plan
1. **Reset sweep.** Preload the table model with 11 everywhere, then hold rst_n=0 for 2 cycles → 1024 consecutive writes of 00 to addresses 0..1023. init_busy falls the cycle after the write to 1023; lk_ready and up_ready rise.
2. **Counter walk.** Updates to 0x0F0 with outcomes T,T,NT,T,NT,NT, each followed by a lookup → lk_state 01,11,10,11,10,00 and lk_pred 0,1,1,1,1,0.
3. **Queue-full arbitration.** Hold lk_valid=1 every cycle and issue 4 updates → up_ready=0 at count 4. lk_ready=0 for one cycle while the head drains; no lookup is lost and all 4 writes land in order.
4. **Simultaneous request.** lk_valid and up_valid in the same cycle, both to 0x005 with counter 00, taken → the lookup wins and returns 00 (stale). The update is written on the next idle cycle; a subsequent lookup returns 01.
5. **Reset mid-operation.** 3 updates queued, then rst_n=0 for 1 cycle during a drain → queue empty, no further update writes, sweep restarts at address 0, lk_pred_valid=0.
6. **Idle.** RUN with no requests → tbl_we stays 0 and lk_pred_valid stays 0.

Source files
------------

// File: rtl/bht_ctrl.sv
// Branch history table controller: arbitrates the single table port between
// prediction lookups and queued counter updates, and clears the table after reset.
module bht_ctrl #(
  parameter int ADDR_W = 10,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lk_valid,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_ready,
  output logic              lk_pred_valid,
  output logic              lk_pred,
  output logic [1:0]        lk_state,
  input  logic              up_valid,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic              up_taken,
  output logic              up_ready,
  output logic [ADDR_W-1:0] tbl_addr,
  output logic              tbl_we,
  output logic [1:0]        tbl_wdata,
  input  logic [1:0]        tbl_rdata,
  output logic              init_busy
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QDEPTH);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              pv_q, pv_d;
  logic [1:0]        st_q, st_d;
  logic [ADDR_W-1:0] q_addr_q [QDEPTH];
  logic              q_taken_q [QDEPTH];

  logic full, enq, deq, lk_hs;

  function automatic logic [1:0] ctr_next(input logic [1:0] s, input logic taken);
    logic [1:0] n;
    unique case (s)
      2'b00:   n = taken ? 2'b01 : 2'b00;
      2'b01:   n = taken ? 2'b11 : 2'b00;
      2'b10:   n = taken ? 2'b11 : 2'b00;
      default: n = taken ? 2'b11 : 2'b10;
    endcase
    return n;
  endfunction

  assign full = (count_q == FULL_CNT);

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    tbl_addr  = '0;
    tbl_we    = 1'b0;
    tbl_wdata = 2'b00;
    lk_ready  = 1'b0;
    up_ready  = 1'b0;
    init_busy = 1'b1;
    lk_hs     = 1'b0;
    enq       = 1'b0;
    deq       = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_INIT: begin
          tbl_addr = sweep_q;
          tbl_we   = 1'b1;
          sweep_d  = sweep_q + ADDR_W'(1);
          if (sweep_q == {ADDR_W{1'b1}}) state_d = S_RUN;
        end
        default: begin
          init_busy = 1'b0;
          lk_ready  = !full;
          up_ready  = !full;
          enq       = up_valid && !full;
          // A full queue steals the port from lookups so updates cannot starve forever.
          if (full || (!lk_valid && count_q != '0)) begin
            deq       = 1'b1;
            tbl_addr  = q_addr_q[head_q];
            tbl_we    = 1'b1;
            tbl_wdata = ctr_next(tbl_rdata, q_taken_q[head_q]);
          end else if (lk_valid) begin
            lk_hs    = 1'b1;
            tbl_addr = lk_addr;
          end
        end
      endcase
    end
  end

  always_comb begin
    head_d = deq ? head_q + PTR_W'(1) : head_q;
    tail_d = enq ? tail_q + PTR_W'(1) : tail_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    pv_d = lk_hs;
    st_d = lk_hs ? tbl_rdata : st_q;
  end

  // Stage boundary: control state, queue pointers and lookup response register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pv_q    <= 1'b0;
      st_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pv_q    <= pv_d;
      st_q    <= st_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr_q[tail_q]  <= up_addr;
      q_taken_q[tail_q] <= up_taken;
    end
  end

  assign lk_pred_valid = pv_q;
  assign lk_state      = st_q;
  assign lk_pred       = st_q[1];
endmodule

// File: tb/tb_bht_ctrl.sv
// Directed bench for bht_ctrl with a behavioural table, a write scoreboard
// and a lookup-response scoreboard.
module tb_bht_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       lk_valid, up_valid, up_taken;
  logic [9:0] lk_addr, up_addr;
  logic       lk_ready, lk_pred_valid, lk_pred, up_ready, tbl_we, init_busy;
  logic [1:0] lk_state, tbl_wdata, tbl_rdata;
  logic [9:0] tbl_addr;

  int checks = 0;
  int errors = 0;

  logic [1:0]  mem     [1024];
  logic [1:0]  tbl_ref [1024];
  logic [1:0]  ref_ctr [1024];
  logic [11:0] exp_wr  [$];
  logic [1:0]  exp_rsp [$];
  int          sweep_exp = 0;
  int          n;

  logic       walk_t [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [1:0] walk_s [6] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00};

  bht_ctrl #(.ADDR_W(10), .QDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
    .lk_pred_valid(lk_pred_valid), .lk_pred(lk_pred), .lk_state(lk_state),
    .up_valid(up_valid), .up_addr(up_addr), .up_taken(up_taken), .up_ready(up_ready),
    .tbl_addr(tbl_addr), .tbl_we(tbl_we), .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  assign tbl_rdata = mem[tbl_addr];
  always @(posedge clk) if (tbl_we === 1'b1) mem[tbl_addr] <= tbl_wdata;

  function automatic logic [1:0] nxt(input logic [1:0] s, input logic t);
    case ({s, t})
      3'b000: return 2'b00;
      3'b001: return 2'b01;
      3'b010: return 2'b00;
      3'b011: return 2'b11;
      3'b100: return 2'b00;
      3'b101: return 2'b11;
      3'b110: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [9:0] la, input logic uv,
                       input logic [9:0] ua, input logic ut);
    lk_valid = lv; lk_addr = la; up_valid = uv; up_addr = ua; up_taken = ut;
    #1;
    if (lv && lk_ready === 1'b1) exp_rsp.push_back(tbl_ref[la]);
    if (uv && up_ready === 1'b1) begin
      ref_ctr[ua] = nxt(ref_ctr[ua], ut);
      exp_wr.push_back({ua, ref_ctr[ua]});
    end
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // Lookup responses are compared against the committed-table model.
  always @(negedge clk) begin
    if (lk_pred_valid === 1'b1) begin
      if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(exp_rsp.size()), 32'd1);
      else begin
        logic [1:0] e;
        e = exp_rsp.pop_front();
        chk("rsp_state", 32'(lk_state), 32'(e));
        chk("rsp_pred", 32'(lk_pred), 32'(e[1]));
      end
    end
  end

  // Table writes: sweep writes in address order, then queued updates in FIFO order.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b0) chk("we_in_reset", 32'(tbl_we), 32'd0);
    else if (tbl_we === 1'b1) begin
      if (init_busy === 1'b1) begin
        chk("sweep_addr", 32'(tbl_addr), 32'(sweep_exp));
        chk("sweep_data", 32'(tbl_wdata), 32'd0);
        tbl_ref[sweep_exp[9:0]] = 2'b00;
        sweep_exp++;
      end else if (exp_wr.size() == 0) begin
        chk("unexpected_write", 32'(exp_wr.size()), 32'd1);
      end else begin
        logic [11:0] w;
        w = exp_wr.pop_front();
        chk("wr_addr", 32'(tbl_addr), 32'(w[11:2]));
        chk("wr_data", 32'(tbl_wdata), 32'(w[1:0]));
        tbl_ref[w[11:2]] = w[1:0];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 2'b11; tbl_ref[i] = 2'b11; ref_ctr[i] = 2'b00;
    end
    rst_n = 1'b0;
    lk_valid = 1'b0; lk_addr = '0; up_valid = 1'b0; up_addr = '0; up_taken = 1'b0;

    // Reset and full clear sweep
    repeat (2) @(negedge clk);
    #1;
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_lk_ready", 32'(lk_ready), 32'd0);
    chk("rst_up_ready", 32'(up_ready), 32'd0);
    chk("rst_pred_valid", 32'(lk_pred_valid), 32'd0);
    chk("rst_lk_state", 32'(lk_state), 32'd0);
    chk("rst_lk_pred", 32'(lk_pred), 32'd0);
    chk("rst_tbl_we", 32'(tbl_we), 32'd0);
    rst_n = 1'b1;
    n = 0;
    while (init_busy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("sweep_cycles", 32'(n), 32'd1024);
    chk("sweep_count", 32'(sweep_exp), 32'd1024);
    #1;
    chk("run_lk_ready", 32'(lk_ready), 32'd1);
    chk("run_up_ready", 32'(up_ready), 32'd1);
    chk("mem0_cleared", 32'(mem[0]), 32'd0);
    chk("mem1023_cleared", 32'(mem[1023]), 32'd0);

    // Idle: no table writes, no responses
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); idle();
      chk("idle_we", 32'(tbl_we), 32'd0);
      chk("idle_addr", 32'(tbl_addr), 32'd0);
      chk("idle_pred_valid", 32'(lk_pred_valid), 32'd0);
    end

    // Counter walk on 0x0F0
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); drive(1'b0, '0, 1'b1, 10'h0F0, walk_t[k]);
      chk("walk_up_ready", 32'(up_ready), 32'd1);
      @(negedge clk); idle();
      chk("walk_drain_we", 32'(tbl_we), 32'd1);
      chk("walk_drain_data", 32'(tbl_wdata), 32'(walk_s[k]));
      @(negedge clk); drive(1'b1, 10'h0F0, 1'b0, '0, 1'b0);
      @(negedge clk); idle();
      chk("walk_state", 32'(lk_state), 32'(walk_s[k]));
      chk("walk_pred", 32'(lk_pred), 32'(walk_s[k][1]));
    end

    // Simultaneous lookup and update to 0x005: lookup wins and sees the old value
    @(negedge clk); drive(1'b1, 10'h005, 1'b1, 10'h005, 1'b1);
    chk("sim_lk_ready", 32'(lk_ready), 32'd1);
    chk("sim_no_write", 32'(tbl_we), 32'd0);
    @(negedge clk); idle();
    chk("sim_stale_valid", 32'(lk_pred_valid), 32'd1);
    chk("sim_stale_state", 32'(lk_state), 32'd0);
    chk("sim_drain_we", 32'(tbl_we), 32'd1);
    chk("sim_drain_addr", 32'(tbl_addr), 32'h005);
    @(negedge clk); drive(1'b1, 10'h005, 1'b0, '0, 1'b0);
    @(negedge clk); idle();
    chk("sim_new_state", 32'(lk_state), 32'd1);

    // Queue-full arbitration under continuous lookups
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1'b1, 10'h100 + 10'(i), 1'b1, 10'h200 + 10'(i), i[0]);
      chk("qf_lk_ready", 32'(lk_ready), 32'd1);
      chk("qf_up_ready", 32'(up_ready), 32'd1);
    end
    @(negedge clk); drive(1'b1, 10'h104, 1'b1, 10'h3FF, 1'b1);
    chk("qf_full_lk_ready", 32'(lk_ready), 32'd0);
    chk("qf_full_up_ready", 32'(up_ready), 32'd0);
    chk("qf_full_drain_addr", 32'(tbl_addr), 32'h200);
    @(negedge clk); drive(1'b1, 10'h105, 1'b0, '0, 1'b0);
    chk("qf_after_lk_ready", 32'(lk_ready), 32'd1);
    chk("qf_after_no_write", 32'(tbl_we), 32'd0);
    for (int i = 0; i < 5; i++) begin @(negedge clk); idle(); end
    chk("qf_drained", 32'(exp_wr.size()), 32'd0);
    chk("qf_rsp_done", 32'(exp_rsp.size()), 32'd0);

    // Reset during a drain discards the queue and restarts the sweep
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1'b1, 10'h010 + 10'(i), 1'b1, 10'h300 + 10'(i), 1'b1);
    end
    @(negedge clk); idle();
    chk("mid_drain_addr", 32'(tbl_addr), 32'h300);
    @(negedge clk);
    rst_n = 1'b0;
    exp_wr.delete();
    exp_rsp.delete();
    for (int i = 0; i < 1024; i++) ref_ctr[i] = 2'b00;
    sweep_exp = 0;
    idle();
    chk("mid_rst_we", 32'(tbl_we), 32'd0);
    @(negedge clk); #1;
    chk("mid_rst_pred_valid", 32'(lk_pred_valid), 32'd0);
    chk("mid_rst_init_busy", 32'(init_busy), 32'd1);
    chk("mid_rst_up_ready", 32'(up_ready), 32'd0);
    rst_n = 1'b1;
    n = 0;
    while (init_busy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("resweep_cycles", 32'(n), 32'd1024);
    chk("resweep_count", 32'(sweep_exp), 32'd1024);
    for (int i = 0; i < 4; i++) begin @(negedge clk); idle(); end
    @(negedge clk); drive(1'b1, 10'h301, 1'b0, '0, 1'b0);
    @(negedge clk); idle();
    chk("mid_discarded_state", 32'(lk_state), 32'd0);
    @(negedge clk); idle();
    chk("final_wr_empty", 32'(exp_wr.size()), 32'd0);
    chk("final_rsp_empty", 32'(exp_rsp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
